// File: rtl/window_mac_pkg.sv
// Shared constants, FSM state type and saturation helper for the
// depthwise sign-weight MAC that consumes 3x3 windows.
package window_mac_pkg;

    localparam int KSIZE     = 3;
    localparam int CORE_SIZE = KSIZE * KSIZE;
    localparam int DW        = 16;
    // Nine taps of magnitude up to 2^15 plus a bias fit in DW+5 signed bits.
    localparam int ACCW      = DW + 5;
    localparam int ROW_W     = 2;
    localparam int VS_STAGES = 4;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(KSIZE - 1);

    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } state_t;

    // Clamp an accumulator-width value into the signed DW-bit output range.
    function automatic logic [DW-1:0] saturate(input logic signed [ACCW-1:0] v);
        logic [DW-1:0] r;
        if (v > SAT_MAX) begin
            r = {1'b0, {(DW-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/window_sign_mac_sign_row_adder.sv
// One kernel row for one channel: adds or subtracts each tap according to
// its binary sign weight. Taps are widened before negation so that
// -(-32768) becomes +32768 instead of wrapping.
module sign_row_adder
    import window_mac_pkg::*;
(
    input  logic [KSIZE-1:0][DW-1:0] taps,
    input  logic [KSIZE-1:0]         signs,
    output logic signed [ACCW-1:0]   row_sum
);

    logic signed [ACCW-1:0] ext;
    logic signed [ACCW-1:0] sum;

    // Sign-extend every tap, then add or subtract it into the row sum.
    always_comb begin
        ext = '0;
        sum = '0;
        for (int i = 0; i < KSIZE; i++) begin
            ext = {{(ACCW-DW){taps[i][DW-1]}}, taps[i]};
            if (signs[i]) begin
                sum = sum - ext;
            end else begin
                sum = sum + ext;
            end
        end
        row_sum = sum;
    end

endmodule

// File: rtl/window_sign_mac.sv
// Depthwise 3x3 binary-sign MAC. A window is latched on data_in_valid,
// accumulated one kernel row per cycle, biased and saturated, and emitted
// four cycles after acceptance. All channels share one FSM and row counter.
module window_sign_mac
    import window_mac_pkg::*;
#(
    parameter int FM_DEPTH = 64
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic                                        vs_in,
    input  logic                                        data_in_valid,
    input  logic [FM_DEPTH-1:0][CORE_SIZE-1:0][DW-1:0]  data_in,
    input  logic [FM_DEPTH-1:0][CORE_SIZE-1:0]          weight_sign,
    input  logic [FM_DEPTH-1:0][DW-1:0]                 bias,
    output logic [FM_DEPTH-1:0][DW-1:0]                 data_out,
    output logic                                        data_out_valid,
    output logic                                        vs_out,
    output logic                                        busy,
    output logic                                        overrun
);

    state_t state;
    state_t next_state;

    logic [ROW_W-1:0] row_cnt;
    logic             load_en;
    logic             acc_en;
    logic             sat_en;
    logic             drop;

    logic [FM_DEPTH-1:0][CORE_SIZE-1:0][DW-1:0] win_data;
    logic [FM_DEPTH-1:0][CORE_SIZE-1:0]         win_sign;
    logic [FM_DEPTH-1:0][DW-1:0]                win_bias;

    logic signed [ACCW-1:0] acc     [FM_DEPTH];
    logic signed [ACCW-1:0] row_sum [FM_DEPTH];

    logic [VS_STAGES-1:0] vs_sr;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic: accept only in IDLE, three row cycles, one saturate cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (data_in_valid) begin
                    next_state = ACC;
                end else begin
                    next_state = IDLE;
                end
            end
            ACC: begin
                if (row_cnt == ROW_LAST) begin
                    next_state = SAT;
                end else begin
                    next_state = ACC;
                end
            end
            SAT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM control decode: load, accumulate, saturate, and drop strobes.
    always_comb begin
        load_en = 1'b0;
        acc_en  = 1'b0;
        sat_en  = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: begin
                load_en = data_in_valid;
            end
            ACC: begin
                acc_en = 1'b1;
                drop   = data_in_valid;
            end
            SAT: begin
                sat_en = 1'b1;
                drop   = data_in_valid;
            end
            default: begin
                load_en = 1'b0;
            end
        endcase
    end

    // Row counter selecting which kernel row feeds the adders.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_cnt <= '0;
        end else if (load_en) begin
            row_cnt <= '0;
        end else if (acc_en) begin
            if (row_cnt == ROW_LAST) begin
                row_cnt <= '0;
            end else begin
                row_cnt <= row_cnt + 2'd1;
            end
        end
    end

    // Window registers: capture taps, signs and bias on acceptance only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_data <= '0;
            win_sign <= '0;
            win_bias <= '0;
        end else if (load_en) begin
            win_data <= data_in;
            win_sign <= weight_sign;
            win_bias <= bias;
        end
    end

    // Per-channel row selection and signed row adder.
    for (genvar c = 0; c < FM_DEPTH; c++) begin : g_ch
        logic [KSIZE-1:0][DW-1:0] row_taps;
        logic [KSIZE-1:0]         row_signs;

        // Route the current kernel row of this channel to its adder.
        always_comb begin
            row_taps  = '0;
            row_signs = '0;
            case (row_cnt)
                2'd0: begin
                    row_taps  = win_data[c][KSIZE-1:0];
                    row_signs = win_sign[c][KSIZE-1:0];
                end
                2'd1: begin
                    row_taps  = win_data[c][2*KSIZE-1:KSIZE];
                    row_signs = win_sign[c][2*KSIZE-1:KSIZE];
                end
                2'd2: begin
                    row_taps  = win_data[c][3*KSIZE-1:2*KSIZE];
                    row_signs = win_sign[c][3*KSIZE-1:2*KSIZE];
                end
                default: begin
                    row_taps  = '0;
                    row_signs = '0;
                end
            endcase
        end

        sign_row_adder u_row_adder (
            .taps    (row_taps),
            .signs   (row_signs),
            .row_sum (row_sum[c])
        );
    end

    // Accumulators: cleared on acceptance, one row added per ACC cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < FM_DEPTH; c++) begin
                acc[c] <= '0;
            end
        end else begin
            for (int c = 0; c < FM_DEPTH; c++) begin
                if (load_en) begin
                    acc[c] <= '0;
                end else if (acc_en) begin
                    acc[c] <= acc[c] + row_sum[c];
                end
            end
        end
    end

    // Result register: add bias, saturate, pulse valid; result holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= sat_en;
            if (sat_en) begin
                for (int c = 0; c < FM_DEPTH; c++) begin
                    data_out[c] <= saturate(acc[c] +
                        $signed({{(ACCW-DW){win_bias[c][DW-1]}}, win_bias[c]}));
                end
            end
        end
    end

    // Busy flag registered from the next state so it equals state != IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
        end
    end

    // Frame-start delay line aligning vs with the result stream.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_sr <= '0;
        end else begin
            vs_sr <= {vs_sr[VS_STAGES-2:0], vs_in};
        end
    end

    assign vs_out = vs_sr[VS_STAGES-1];

    // Sticky overrun: a drop sets it, a frame start clears it, set has priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (vs_in) begin
            overrun <= 1'b0;
        end
    end

endmodule
